// File: rtl/keymem_arbiter_if.sv
// keymem_arbiter_if: groups the per-path key request bus and the single keymem
// key port shared by keymem_arbiter.
//   path_key_req / path_key_id           requests from the network paths
//   path_key_ack / path_key_err / path_key   acknowledge, error flag and key back to the paths
//   km_key_req / km_key_id               lookup issued to keymem_top
//   km_key_ack / km_key                  keymem_top response
// Modport slave is the arbiter's view. Modport master is the environment's view
// (the paths plus keymem).
interface keymem_arbiter_if #(
  parameter int unsigned NUM_PATHS = 4
) ();
  logic [NUM_PATHS-1:0]    path_key_req;
  logic [32*NUM_PATHS-1:0] path_key_id;
  logic [NUM_PATHS-1:0]    path_key_ack;
  logic [NUM_PATHS-1:0]    path_key_err;
  logic [255:0]            path_key;
  logic                    km_key_req;
  logic [31:0]             km_key_id;
  logic                    km_key_ack;
  logic [255:0]            km_key;

  modport slave (
    input  path_key_req, path_key_id, km_key_ack, km_key,
    output path_key_ack, path_key_err, path_key, km_key_req, km_key_id
  );

  modport master (
    output path_key_req, path_key_id, km_key_ack, km_key,
    input  path_key_ack, path_key_err, path_key, km_key_req, km_key_id
  );
endinterface

// File: rtl/keymem_arbiter.sv
// keymem_arbiter: round-robin arbiter that serialises key lookups from up to
// NUM_PATHS network paths onto one keymem_top key port. It runs one lookup at a
// time, latches the returned key and pulses the acknowledge to the granted path.
//
// Ports:
//   key_clk      key-domain clock (clk156)
//   key_aresetn  asynchronous reset, active low
//   bus          keymem_arbiter_if.slave; carries the path request/ack bus and the keymem port
//   busy         high whenever the FSM is not idle
//
// Optional feature: define KEYMEM_ARB_TIMEOUT_EN to bound each lookup to
// TIMEOUT_CYCLES cycles. On timeout the path receives an error ack with a zero key.
// When the macro is not defined, the arbiter waits indefinitely for keymem and
// path_key_err stays 0.
module keymem_arbiter #(
  parameter int unsigned NUM_PATHS      = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic             key_clk,
  input  logic             key_aresetn,
  keymem_arbiter_if.slave  bus,
  output logic             busy
);

  localparam int unsigned GrantW = $clog2(NUM_PATHS);

  if (NUM_PATHS < 2 || NUM_PATHS > 8 || TIMEOUT_CYCLES == 16'd0) begin : g_param_check
    $error("keymem_arbiter: NUM_PATHS must be 2..8 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [GrantW-1:0]    grant_q, grant_d;
  logic [GrantW-1:0]    last_grant_q, last_grant_d;
  logic [31:0]          km_key_id_q, km_key_id_d;
  logic                 km_key_req_q, km_key_req_d;
  logic [255:0]         key_reg_q, key_reg_d;
  logic [NUM_PATHS-1:0] ack_q, ack_d;
  logic [NUM_PATHS-1:0] err_q, err_d;
  logic                 busy_q, busy_d;

  logic                 req_any;
  logic [GrantW-1:0]    winner;
  logic [GrantW-1:0]    cand;
  logic [31:0]          winner_id;
  logic                 timeout;

`ifdef KEYMEM_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_reg_q, err_reg_d;

  assign timeout = (state_q == StWait) && (cnt_q == TIMEOUT_CYCLES - 16'd1);

  always_comb begin
    cnt_d     = cnt_q;
    err_reg_d = err_reg_q;
    if (state_q == StIssue) begin
      cnt_d = 16'd0;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q + 16'd1;
      // An ack on the timeout cycle still wins.
      if (bus.km_key_ack) begin
        err_reg_d = 1'b0;
      end else if (timeout) begin
        err_reg_d = 1'b1;
      end
    end
  end

  always_ff @(posedge key_clk or negedge key_aresetn) begin
    if (!key_aresetn) begin
      cnt_q     <= 16'd0;
      err_reg_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      err_reg_q <= err_reg_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Round-robin pick: the first requester after last_grant_q, wrapping.
  always_comb begin
    winner  = last_grant_q;
    req_any = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_PATHS; k++) begin
      cand = GrantW'((32'(last_grant_q) + k) % NUM_PATHS);
      if (!req_any && bus.path_key_req[cand]) begin
        winner  = cand;
        req_any = 1'b1;
      end
    end
  end

  always_comb begin
    winner_id = '0;
    for (int unsigned p = 0; p < NUM_PATHS; p++) begin
      if (winner == GrantW'(p)) begin
        winner_id = bus.path_key_id[32*p +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge key_clk or negedge key_aresetn) begin
    if (!key_aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A keymem ack outside WAIT is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_any) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (bus.km_key_ack || timeout) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values. Every output is taken from a flop.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    km_key_id_d  = km_key_id_q;
    km_key_req_d = 1'b0;
    key_reg_d    = key_reg_q;
    ack_d        = '0;
    err_d        = '0;
    busy_d       = (state_d != StIdle);
    case (state_q)
      StIdle: begin
        if (req_any) begin
          grant_d      = winner;
          km_key_id_d  = winner_id;
          km_key_req_d = 1'b1;
        end
      end
      StWait: begin
        if (bus.km_key_ack) begin
          key_reg_d = bus.km_key;
        end else if (timeout) begin
          key_reg_d = '0;
        end
        if (state_d == StResp) begin
          ack_d[grant_q] = 1'b1;
`ifdef KEYMEM_ARB_TIMEOUT_EN
          err_d[grant_q] = err_reg_d;
`endif
        end
      end
      StResp: begin
        last_grant_d = grant_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge key_clk or negedge key_aresetn) begin
    if (!key_aresetn) begin
      grant_q      <= '0;
      last_grant_q <= GrantW'(NUM_PATHS - 1);
      km_key_id_q  <= '0;
      km_key_req_q <= 1'b0;
      key_reg_q    <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      km_key_id_q  <= km_key_id_d;
      km_key_req_q <= km_key_req_d;
      key_reg_q    <= key_reg_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.km_key_req   = km_key_req_q;
  assign bus.km_key_id    = km_key_id_q;
  assign bus.path_key_ack = ack_q;
  assign bus.path_key_err = err_q;
  assign bus.path_key     = key_reg_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_keymem_arbiter.sv
// Self-checking bench for keymem_arbiter: directed scenarios plus a randomized
// run checked against a round-robin reference model.
module tb_keymem_arbiter;
  localparam int unsigned NP = 4;
  localparam logic [15:0] TO = 16'd8;

  logic key_clk = 1'b0;
  logic key_aresetn = 1'b1;
  logic busy;

  keymem_arbiter_if #(.NUM_PATHS(NP)) bus ();

  keymem_arbiter #(.NUM_PATHS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .key_clk(key_clk),
    .key_aresetn(key_aresetn),
    .bus(bus),
    .busy(busy)
  );

  always #5 key_clk = ~key_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [3:0]   o_ack, o_err;
  logic [255:0] o_key;
  logic         o_req, o_busy;
  logic [31:0]  o_id;

  // Keymem responder: acks km_lat cycles after a request (0 = never).
  int           km_lat = 0;
  int           km_cnt = 0;
  logic [255:0] km_val = '0;

  task automatic step();
    @(negedge key_clk);
    cyc++;
    o_ack  = bus.path_key_ack;
    o_err  = bus.path_key_err;
    o_key  = bus.path_key;
    o_req  = bus.km_key_req;
    o_id   = bus.km_key_id;
    o_busy = busy;
    bus.km_key_ack = 1'b0;
    if (km_cnt > 0) begin
      km_cnt--;
      if (km_cnt == 0) begin
        bus.km_key_ack = 1'b1;
        bus.km_key     = km_val;
      end
    end
    if (o_req && km_lat > 0) km_cnt = km_lat;
  endtask

  task automatic apply_reset();
    bus.path_key_req = '0;
    bus.km_key_ack   = 1'b0;
    km_cnt = 0;
    km_lat = 0;
    key_aresetn = 1'b0;
    step();
    step();
    key_aresetn = 1'b1;
    step();
  endtask

  // Steps until a path ack is seen or the bound expires.
  task automatic wait_resp(input int bound, output logic got, output int req_cyc,
                           output int nreq, output logic [31:0] req_id);
    got = 1'b0; req_cyc = -1; nreq = 0; req_id = '0;
    for (int i = 0; i < bound && !got; i++) begin
      step();
      if (o_req) begin
        nreq++;
        if (req_cyc < 0) begin
          req_cyc = cyc;
          req_id  = o_id;
        end
      end
      if (o_ack != 4'b0) got = 1'b1;
    end
  endtask

  function automatic int rr(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      int idx = (last + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic test_reset();
    bus.path_key_req = '0; bus.path_key_id = '0; bus.km_key_ack = 1'b0; bus.km_key = '0;
    #1 key_aresetn = 1'b0;
    #2;
    total++;
    if ({busy, bus.km_key_req, bus.path_key_ack, bus.path_key_err} !== 10'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 0",
               {busy, bus.km_key_req, bus.path_key_ack, bus.path_key_err});
    end
    total++;
    if (bus.path_key !== 256'b0 || bus.km_key_id !== 32'b0) begin
      bad++;
      $display("FAIL reset_data: key %0h id %0h required 0", bus.path_key, bus.km_key_id);
    end
    step();
    key_aresetn = 1'b1;
    step(); step();
    total++;
    if (o_busy !== 1'b0 || o_req !== 1'b0 || o_ack !== 4'b0) begin
      bad++;
      $display("FAIL reset_idle: busy %b req %b ack %b required 0", o_busy, o_req, o_ack);
    end
  endtask

  task automatic test_single();
    logic got; int rc, nreq; logic [31:0] rid;
    apply_reset();
    km_lat = 3;
    km_val = {32{8'hA5}};
    bus.path_key_id[64 +: 32] = 32'h0000_0005;
    bus.path_key_req = 4'b0100;
    wait_resp(50, got, rc, nreq, rid);
    total++;
    if (!got) begin bad++; $display("FAIL single_ack_seen: no ack within 50 cycles"); end
    total++;
    if (nreq != 1 || rid !== 32'h5) begin
      bad++; $display("FAIL single_req: pulses %0d id %0h required 1 and 5", nreq, rid);
    end
    total++;
    if (cyc - rc != 4) begin
      bad++; $display("FAIL single_latency: got %0d required 4", cyc - rc);
    end
    total++;
    if (o_ack !== 4'b0100 || o_err !== 4'b0 || o_key !== {32{8'hA5}}) begin
      bad++;
      $display("FAIL single_resp: ack %b err %b key %0h required 0100 0000 a5..a5",
               o_ack, o_err, o_key);
    end
    bus.path_key_req = '0;
    step();
    total++;
    if (o_ack !== 4'b0) begin bad++; $display("FAIL single_one_pulse: ack %b required 0", o_ack); end
  endtask

  task automatic test_fairness();
    logic got; int rc, nreq, prev, expg; logic [31:0] rid; logic [3:0] expv;
    apply_reset();
    km_lat = 1;
    for (int p = 0; p < 4; p++) bus.path_key_id[32*p +: 32] = 32'h100 + p;
    bus.path_key_req = 4'b1111;
    prev = 0;
    expg = rr(4'b1111, 3);
    for (int i = 0; i < 5; i++) begin
      wait_resp(40, got, rc, nreq, rid);
      expv = 4'b0001 << expg;
      total++;
      if (!got || o_ack !== expv || rid !== 32'h100 + expg) begin
        bad++;
        $display("FAIL fair_grant%0d: ack %b id %0h required %b %0h", i, o_ack, rid, expv,
                 32'h100 + expg);
      end
      if (i > 0) begin
        total++;
        if (cyc - prev != 4) begin
          bad++; $display("FAIL fair_spacing%0d: got %0d required 4", i, cyc - prev);
        end
      end
      prev = cyc;
      expg = rr(4'b1111, expg);
    end
    bus.path_key_req = '0;
  endtask

  task automatic test_timeout();
    logic got; int rc, nreq; logic [31:0] rid;
    apply_reset();
    km_lat = 0;
    bus.path_key_id[32 +: 32] = 32'h0000_0077;
`ifdef KEYMEM_ARB_TIMEOUT_EN
    bus.path_key_req = 4'b0010;
    wait_resp(40, got, rc, nreq, rid);
    total++;
    if (!got || cyc - rc != int'(TO) + 1) begin
      bad++; $display("FAIL timeout_latency: got %0b/%0d required %0d", got, cyc - rc, TO + 1);
    end
    total++;
    if (o_ack !== 4'b0010 || o_err !== 4'b0010 || o_key !== 256'b0) begin
      bad++; $display("FAIL timeout_resp: ack %b err %b key %0h required 0010 0010 0",
                      o_ack, o_err, o_key);
    end
    bus.path_key_req = '0;
`else
    begin
      int nack = 0, nidle = 0;
      bus.path_key_req = 4'b0010;
      for (int i = 0; i < 100; i++) begin
        step();
        if (o_ack != 4'b0) nack++;
        if (o_busy !== 1'b1) nidle++;
      end
      total++;
      if (nack != 0) begin bad++; $display("FAIL notimeout_ack: got %0d acks required 0", nack); end
      total++;
      if (nidle != 0) begin bad++; $display("FAIL notimeout_busy: idle %0d cycles required 0", nidle); end
      bus.path_key_req = '0;
    end
`endif
  endtask

  task automatic test_simultaneous();
    logic got; int rc, nreq, nack, nbusy; logic [31:0] rid; logic [255:0] k;
    apply_reset();
    km_lat = int'(TO);
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    km_val = k;
    bus.path_key_id[96 +: 32] = 32'h3333_0003;
    bus.path_key_req = 4'b1000;
    wait_resp(40, got, rc, nreq, rid);
    total++;
    if (!got || cyc - rc != int'(TO) + 1) begin
      bad++; $display("FAIL tie_latency: got %0b/%0d required %0d", got, cyc - rc, TO + 1);
    end
    total++;
    if (o_ack !== 4'b1000 || o_err !== 4'b0 || o_key !== k) begin
      bad++; $display("FAIL tie_resp: ack %b err %b key %0h required 1000 0000 %0h",
                      o_ack, o_err, o_key, k);
    end
    bus.path_key_req = '0;
    step(); step();
    bus.km_key_ack = 1'b1;
    bus.km_key = '1;
    nack = 0; nbusy = 0; nreq = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_ack != 4'b0) nack++;
      if (o_busy) nbusy++;
      if (o_req) nreq++;
    end
    total++;
    if (nack != 0 || nbusy != 0 || nreq != 0) begin
      bad++; $display("FAIL spurious_ack: acks %0d busy %0d reqs %0d required 0 0 0",
                      nack, nbusy, nreq);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic got; int rc, nreq, nack, nbusy; logic [31:0] rid;
    apply_reset();
    km_lat = 0;
    bus.path_key_id[32 +: 32] = 32'hDEAD_BEEF;
    bus.path_key_req = 4'b0010;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin step(); got = o_req; end
    step(); step();
    total++;
    if (!got || o_busy !== 1'b1 || o_id !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL midwait_setup: req %b busy %b id %0h required 1 1 deadbeef",
                      got, o_busy, o_id);
    end
    #2 key_aresetn = 1'b0;
    #1;
    total++;
    if ({busy, bus.km_key_req, bus.path_key_ack, bus.path_key_err} !== 10'b0 ||
        bus.km_key_id !== 32'b0 || bus.path_key !== 256'b0) begin
      bad++; $display("FAIL midwait_async: busy %b id %0h ack %b required all 0",
                      busy, bus.km_key_id, bus.path_key_ack);
    end
    bus.path_key_req = '0;
    step();
    key_aresetn = 1'b1;
    bus.km_key_ack = 1'b1;
    bus.km_key = '1;
    nack = 0; nbusy = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_ack != 4'b0) nack++;
      if (o_busy) nbusy++;
    end
    total++;
    if (nack != 0 || nbusy != 0) begin
      bad++; $display("FAIL midwait_late_ack: acks %0d busy %0d required 0 0", nack, nbusy);
    end
    km_lat = 1;
    bus.path_key_id[0 +: 32] = 32'h0;
    bus.path_key_id[96 +: 32] = 32'h3;
    bus.path_key_req = 4'b1001;
    wait_resp(30, got, rc, nreq, rid);
    total++;
    if (!got || o_ack !== 4'b0001) begin
      bad++; $display("FAIL midwait_prio0: ack %b required 0001", o_ack);
    end
    bus.path_key_req = 4'b1000;
    wait_resp(30, got, rc, nreq, rid);
    total++;
    if (!got || o_ack !== 4'b1000 || rid !== 32'h3) begin
      bad++; $display("FAIL midwait_then3: ack %b id %0h required 1000 3", o_ack, rid);
    end
    bus.path_key_req = '0;
  endtask

  task automatic test_withdrawn();
    logic got; int rc, nreq, nack, nextra; logic [31:0] rid;
    apply_reset();
    km_lat = 5;
    bus.path_key_id[0 +: 32] = 32'h0000_00A0;
    bus.path_key_req = 4'b0001;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin step(); got = o_req; end
    step();
    bus.path_key_req = '0;
    wait_resp(20, got, rc, nreq, rid);
    total++;
    if (!got || o_ack !== 4'b0001 || nreq != 0) begin
      bad++; $display("FAIL withdrawn_ack: ack %b extra reqs %0d required 0001 0", o_ack, nreq);
    end
    nack = 0; nextra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_ack != 4'b0) nack++;
      if (o_req) nextra++;
    end
    total++;
    if (nack != 0 || nextra != 0) begin
      bad++; $display("FAIL withdrawn_quiet: acks %0d reqs %0d required 0 0", nack, nextra);
    end
  endtask

  task automatic test_random();
    logic [3:0] req_drv, req_prev, expv;
    logic [31:0] ids [NP];
    logic [255:0] exp_key;
    int model_last, exp_g, ntx;
    apply_reset();
    req_drv = '0; model_last = NP - 1; exp_g = 0; ntx = 0; exp_key = '0;
    for (int p = 0; p < int'(NP); p++) ids[p] = '0;
    km_lat = 1;
    for (int c = 0; c < 3000 && ntx < 40; c++) begin
      req_prev = req_drv;
      step();
      if (o_req) begin
        exp_g = rr(req_prev, model_last);
        total++;
        if (exp_g < 0 || o_id !== ids[exp_g < 0 ? 0 : exp_g]) begin
          bad++; $display("FAIL rand_grant_id: id %0h path %0d", o_id, exp_g);
          if (exp_g < 0) exp_g = 0;
        end
        km_val = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        exp_key = km_val;
      end
      if (o_ack != 4'b0) begin
        expv = 4'b0001 << exp_g;
        total++;
        if (o_ack !== expv || o_err !== 4'b0 || o_key !== exp_key) begin
          bad++; $display("FAIL rand_resp: ack %b err %b key %0h required %b 0000 %0h",
                          o_ack, o_err, o_key, expv, exp_key);
        end
        model_last = exp_g;
        req_drv[exp_g] = 1'b0;
        ntx++;
      end
      km_lat = $urandom_range(1, 6);
      for (int p = 0; p < int'(NP); p++) begin
        if (!req_drv[p] && !o_ack[p] && $urandom_range(0, 3) == 0) begin
          ids[p] = $urandom;
          req_drv[p] = 1'b1;
        end
      end
      for (int p = 0; p < int'(NP); p++) bus.path_key_id[32*p +: 32] = ids[p];
      bus.path_key_req = req_drv;
    end
    total++;
    if (ntx != 40) begin bad++; $display("FAIL rand_count: got %0d required 40", ntx); end
    bus.path_key_req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_simultaneous();
    test_reset_mid_wait();
    test_withdrawn();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
